// File: rtl/i2c_pkg.sv
// Shared I2C definitions: widths, line-level constants, receiver state enum.
package i2c_pkg;

  localparam int I2C_ADDR_W = 7;
  localparam int I2C_DATA_W = 8;

  // Line level a receiver presents in the acknowledge slot.
  localparam logic ACK  = 1'b0;
  localparam logic NACK = 1'b1;

  // Number of bits in one address or data byte (bit counter is 4 bits wide).
  localparam logic [3:0] BYTE_BITS = 4'd8;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ADDR      = 3'd1,
    ADDR_ACK  = 3'd2,
    DATA      = 3'd3,
    DATA_ACK  = 3'd4,
    WAIT_STOP = 3'd5
  } i2c_state_e;

  // Open-drain enable needed to put a given level on SDA (only 0 can be driven).
  function automatic logic oe_for(input logic line_bit);
    return (line_bit == 1'b0);
  endfunction

  // True when an address byte selects this slave for a write transfer.
  function automatic logic addr_hit(input logic [I2C_DATA_W-1:0] addr_byte,
                                    input logic [I2C_ADDR_W-1:0] own_addr);
    return (addr_byte[7:1] == own_addr) && (addr_byte[0] == 1'b0);
  endfunction

endpackage

// File: rtl/i2c_sync_edge.sv
// Multi-flop synchronizer for one bus line plus rise/fall detection against
// the previous synchronized level. Flops reset to 1, the idle bus level.
module i2c_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic pclk,
  input  logic presetn,
  input  logic d_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  // Shift the raw line through the synchronizer and remember the last level.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      sync_q <= '1;
      prev_q <= 1'b1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign level_o = sync_q[SYNC_STAGES-1];
  assign rise_o  = level_o & ~prev_q;
  assign fall_o  = ~level_o & prev_q;

endmodule

// File: rtl/i2c_slave_rx.sv
// Write-only I2C slave receiver. Matches its own 7-bit address, ACKs accepted
// bytes and hands each data byte to the consumer with a one-pclk valid pulse.
//
// Consumer handshake: rx_ready is sampled on the SCL falling edge that ends a
// data byte. If it is 1 the byte is taken: data_slave_read is loaded and
// data_slave_read_valid pulses for exactly one pclk (no stall is possible, the
// consumer must accept in that cycle). If it is 0 the byte is NACKed and no
// pulse is produced. data_slave_read holds its value until the next accepted
// byte.
module i2c_slave_rx
  import i2c_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic                  pclk,
  input  logic                  presetn,
  input  logic                  scl_i,
  input  logic                  sda_i,
  output logic                  sda_oe,
  input  logic [I2C_ADDR_W-1:0] slave_addr,
  input  logic                  rx_ready,
  output logic [I2C_DATA_W-1:0] data_slave_read,
  output logic                  data_slave_read_valid,
  output logic                  busy,
  output logic                  stop_det,
  output i2c_state_e            dbg_state
);

  logic scl_lvl, scl_rise, scl_fall;
  logic sda_lvl, sda_rise, sda_fall;
  logic start_evt, stop_evt;

  i2c_state_e            state, state_nxt;
  logic [3:0]            bit_cnt, cnt_nxt;
  logic [I2C_DATA_W-1:0] shift, shift_nxt;
  logic [I2C_DATA_W-1:0] data_nxt;
  logic                  oe_nxt, valid_nxt, stop_nxt;

  i2c_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_scl (
    .pclk    (pclk),
    .presetn (presetn),
    .d_i     (scl_i),
    .level_o (scl_lvl),
    .rise_o  (scl_rise),
    .fall_o  (scl_fall)
  );

  i2c_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sda (
    .pclk    (pclk),
    .presetn (presetn),
    .d_i     (sda_i),
    .level_o (sda_lvl),
    .rise_o  (sda_rise),
    .fall_o  (sda_fall)
  );

  // SDA may only change while SCL is high to signal START or STOP.
  assign start_evt = sda_fall & scl_lvl;
  assign stop_evt  = sda_rise & scl_lvl;

  // State and datapath registers.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state                 <= IDLE;
      bit_cnt               <= '0;
      shift                 <= '0;
      sda_oe                <= 1'b0;
      data_slave_read       <= '0;
      data_slave_read_valid <= 1'b0;
      stop_det              <= 1'b0;
    end else begin
      state                 <= state_nxt;
      bit_cnt               <= cnt_nxt;
      shift                 <= shift_nxt;
      sda_oe                <= oe_nxt;
      data_slave_read       <= data_nxt;
      data_slave_read_valid <= valid_nxt;
      stop_det              <= stop_nxt;
    end
  end

  // Next-state and output decode; STOP beats START beats any SCL activity.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = bit_cnt;
    shift_nxt = shift;
    oe_nxt    = sda_oe;
    data_nxt  = data_slave_read;
    valid_nxt = 1'b0;
    stop_nxt  = 1'b0;

    if (stop_evt) begin
      state_nxt = IDLE;
      cnt_nxt   = '0;
      oe_nxt    = oe_for(NACK);
      stop_nxt  = 1'b1;
    end else if (start_evt) begin
      // Also covers repeated START: any partial byte is thrown away.
      state_nxt = ADDR;
      cnt_nxt   = '0;
      shift_nxt = '0;
      oe_nxt    = oe_for(NACK);
    end else begin
      case (state)
        ADDR, DATA: begin
          if (scl_rise && (bit_cnt != BYTE_BITS)) begin
            shift_nxt = {shift[I2C_DATA_W-2:0], sda_lvl};
            cnt_nxt   = bit_cnt + 4'd1;
          end else if (scl_fall && (bit_cnt == BYTE_BITS)) begin
            cnt_nxt = '0;
            if (state == ADDR) begin
              if (addr_hit(shift, slave_addr)) begin
                state_nxt = ADDR_ACK;
                oe_nxt    = oe_for(ACK);
              end else begin
                state_nxt = WAIT_STOP;
                oe_nxt    = oe_for(NACK);
              end
            end else begin
              if (rx_ready) begin
                state_nxt = DATA_ACK;
                oe_nxt    = oe_for(ACK);
                data_nxt  = shift;
                valid_nxt = 1'b1;
              end else begin
                state_nxt = WAIT_STOP;
                oe_nxt    = oe_for(NACK);
              end
            end
          end
        end
        ADDR_ACK, DATA_ACK: begin
          // ACK slot ends on the falling edge after the master sampled it.
          if (scl_fall) begin
            state_nxt = DATA;
            cnt_nxt   = '0;
            oe_nxt    = oe_for(NACK);
          end
        end
        IDLE, WAIT_STOP: begin
          state_nxt = state;
        end
        default: begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
          oe_nxt    = oe_for(NACK);
        end
      endcase
    end
  end

  assign busy      = (state != IDLE);
  assign dbg_state = state;

endmodule

// File: tb/tb_i2c_slave_rx.sv
// Directed bench for i2c_slave_rx: a bit-level I2C master, a transaction-level
// model of what the slave must do, and a per-cycle compare process.
module tb_i2c_slave_rx;
  import i2c_pkg::*;

  localparam int Q = 8; // pclk cycles per quarter SCL period

  // Clock / reset / bus
  logic       pclk = 1'b0;
  logic       presetn = 1'b0;
  logic       scl_m = 1'b1;
  logic       sda_m = 1'b1;
  logic       rx_ready = 1'b1;
  logic [6:0] slave_addr = 7'h3A;
  logic       sda_oe, data_valid, busy, stop_det;
  logic [7:0] data_rd;
  i2c_state_e dbg_state;
  logic       sda_line;

  assign sda_line = sda_m & ~sda_oe;

  always #5 pclk = ~pclk;

  i2c_slave_rx #(.SYNC_STAGES(2)) dut (
    .pclk                  (pclk),
    .presetn               (presetn),
    .scl_i                 (scl_m),
    .sda_i                 (sda_line),
    .sda_oe                (sda_oe),
    .slave_addr            (slave_addr),
    .rx_ready              (rx_ready),
    .data_slave_read       (data_rd),
    .data_slave_read_valid (data_valid),
    .busy                  (busy),
    .stop_det              (stop_det),
    .dbg_state             (dbg_state)
  );

  // Scoreboard and model state
  int         total = 0;
  int         bad = 0;
  logic [7:0] exp_q[$];
  logic [7:0] m_data = 8'h00;
  logic       m_busy = 1'b0;
  logic       m_busy_x = 1'b0;
  logic       m_oe_x = 1'b0;
  int         m_mode = 0; // 0 ignore, 1 expect address, 2 receiving data
  int         stop_seen = 0;
  int         stop_exp = 0;
  int         valid_seen = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle compare against the model
  always @(negedge pclk) begin
    if (data_valid) begin
      valid_seen++;
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_valid: got data %0h want no pulse at %0t", data_rd, $time);
      end else begin
        m_data = exp_q.pop_front();
      end
    end
    check("held_data", data_rd, m_data);
    if (!m_busy_x) check("busy", busy, m_busy);
    if (!m_oe_x) check("oe_outside_ack", sda_oe, 1'b0);
    if (stop_det) stop_seen++;
  end

  // Driver tasks
  task automatic wq();
    repeat (Q) @(posedge pclk);
    #2;
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; wq();
    scl_m = 1'b1; wq();
    m_busy_x = 1'b1;
    sda_m = 1'b0;
    m_mode = 1;
    wq();
    m_busy = 1'b1;
    m_busy_x = 1'b0;
    scl_m = 1'b0; wq();
  endtask

  task automatic send_bit(input logic b);
    sda_m = b; wq();
    scl_m = 1'b1; wq(); wq();
    scl_m = 1'b0; wq();
  endtask

  task automatic send_byte(input logic [7:0] b);
    logic exp_ack;
    case (m_mode)
      1: begin
        exp_ack = (b[7:1] == slave_addr) && (b[0] == 1'b0);
        m_mode = exp_ack ? 2 : 0;
      end
      2: begin
        exp_ack = rx_ready;
        if (rx_ready) exp_q.push_back(b);
        else m_mode = 0;
      end
      default: exp_ack = 1'b0;
    endcase
    for (int i = 7; i >= 1; i--) send_bit(b[i]);
    sda_m = b[0]; wq();
    scl_m = 1'b1; wq(); wq();
    m_oe_x = 1'b1;
    scl_m = 1'b0; wq();
    // acknowledge slot: master releases SDA and samples it mid-high
    sda_m = 1'b1; wq();
    scl_m = 1'b1; wq();
    check($sformatf("ack_oe_%02h", b), sda_oe, exp_ack);
    check($sformatf("ack_line_%02h", b), sda_line, exp_ack ? ACK : NACK);
    wq();
    scl_m = 1'b0; wq();
    m_oe_x = 1'b0;
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; wq();
    scl_m = 1'b1; wq();
    m_busy_x = 1'b1;
    sda_m = 1'b1;
    stop_exp++;
    wq();
    m_busy = 1'b0;
    m_busy_x = 1'b0;
    m_mode = 0;
    wq();
    check("stop_det_count", stop_seen, stop_exp);
  endtask

  // Watchdog
  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout want test end");
    $display("test done: total=%0d bad=%0d", total + 1, bad + 1);
    $fatal(1, "timeout");
  end

  // Directed scenarios
  initial begin
    repeat (3) @(posedge pclk);
    #2;
    check("rst_oe", sda_oe, 1'b0);
    check("rst_valid", data_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_stop", stop_det, 1'b0);
    check("rst_data", data_rd, 8'h00);
    check("rst_state", dbg_state, IDLE);
    presetn = 1'b1;
    wq();

    // valid write: address 0x74 then 0xA5, 0x5A
    i2c_start();
    send_byte(8'h74);
    send_byte(8'hA5);
    check("wr_first_data", data_rd, 8'hA5);
    send_byte(8'h5A);
    check("wr_second_data", data_rd, 8'h5A);
    i2c_stop();
    check("wr_pulses", valid_seen, 2);

    // address mismatch
    i2c_start();
    send_byte(8'h42);
    send_byte(8'hA5);
    i2c_stop();
    check("mis_pulses", valid_seen, 2);
    check("mis_data", data_rd, 8'h5A);

    // read request is refused; later bytes ignored
    i2c_start();
    send_byte(8'h75);
    check("rd_state", dbg_state, WAIT_STOP);
    send_byte(8'h3A);
    send_byte(8'hFF);
    check("rd_state_after", dbg_state, WAIT_STOP);
    i2c_stop();
    check("rd_pulses", valid_seen, 2);

    // backpressure on the second data byte
    i2c_start();
    send_byte(8'h74);
    send_byte(8'hA5);
    rx_ready = 1'b0;
    send_byte(8'h5A);
    check("bp_data", data_rd, 8'hA5);
    check("bp_state", dbg_state, WAIT_STOP);
    rx_ready = 1'b1;
    i2c_stop();
    check("bp_pulses", valid_seen, 3);

    // repeated START after four data bits
    i2c_start();
    send_byte(8'h74);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
    i2c_start();
    send_byte(8'h74);
    send_byte(8'h3C);
    i2c_stop();
    check("rs_pulses", valid_seen, 4);
    check("rs_data", data_rd, 8'h3C);

    // reset during the fifth data bit (SCL high)
    i2c_start();
    send_byte(8'h74);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
    sda_m = 1'b0; wq();
    scl_m = 1'b1; wq();
    m_busy = 1'b0;
    m_data = 8'h00;
    m_mode = 0;
    exp_q.delete();
    presetn = 1'b0;
    #1;
    check("mid_rst_oe", sda_oe, 1'b0);
    check("mid_rst_valid", data_valid, 1'b0);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_stop", stop_det, 1'b0);
    check("mid_rst_data", data_rd, 8'h00);
    scl_m = 1'b0;
    sda_m = 1'b1;
    wq();
    presetn = 1'b1;
    wq(); wq();
    check("post_rst_state", dbg_state, IDLE);
    i2c_start();
    send_byte(8'h74);
    send_byte(8'hC3);
    i2c_stop();
    check("post_rst_pulses", valid_seen, 5);
    check("post_rst_data", data_rd, 8'hC3);

    check("exp_q_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/i2c_slave_rx.md
I2C_SLAVE_RX -- requirements
Module: i2c_slave_rx

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, number of flops in the scl/sda input synchronizers (legal range 2-3).
REQ-002 SHALL have port pclk, input, 1, the single clock for the block.
REQ-003 SHALL have port presetn, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port scl_i, input, 1, raw SCL line level.
REQ-005 SHALL have port sda_i, input, 1, raw SDA line level.
REQ-006 SHALL have port sda_oe, output, 1, open-drain enable; 1 pulls SDA low.
REQ-007 SHALL have port slave_addr, input, 7, own 7-bit address, static during a transfer.
REQ-008 SHALL have port rx_ready, input, 1, consumer can accept a byte.
REQ-009 SHALL have port data_slave_read, output, 8, last received data byte.
REQ-010 SHALL have port data_slave_read_valid, output, 1, one-pclk pulse that qualifies data_slave_read.
REQ-011 SHALL have port busy, output, 1, high from START to STOP.
REQ-012 SHALL have port stop_det, output, 1, one-pclk pulse on STOP.

Function
REQ-013 SHALL sample scl_i and sda_i only through SYNC_STAGES-flop synchronizers, then detect edges by comparing against the previous synchronized value.
REQ-014 SHALL detect START as a falling SDA while SCL is high, and STOP as a rising SDA while SCL is high; with the default parameter, detection occurs 3 pclk after the line event.
REQ-015 SHALL implement these states: IDLE, ADDR, ADDR_ACK, DATA, DATA_ACK, WAIT_STOP.
REQ-016 SHALL enter ADDR with the bit counter cleared on START or repeated START, from any state, and discard any partial byte.
REQ-017 SHALL, on STOP in any state, go to IDLE, release sda_oe the same cycle, and pulse stop_det.
REQ-018 SHALL shift the synchronized SDA in MSB-first on each synchronized SCL rising edge while in ADDR or DATA.
REQ-019 SHALL, on the SCL falling edge after the 8th address bit, behave as follows:
  - if shift[7:1]==slave_addr and shift[0]==0 (write): assert sda_oe and go to ADDR_ACK;
  - otherwise: keep sda_oe low (NACK) and go to WAIT_STOP.
REQ-020 SHALL release sda_oe on the next SCL falling edge in ADDR_ACK or DATA_ACK and enter DATA.
REQ-021 SHALL, on the SCL falling edge after the 8th data bit, behave as follows:
  - if rx_ready=1: load data_slave_read, pulse data_slave_read_valid for one pclk, assert sda_oe, and go to DATA_ACK;
  - if rx_ready=0: NACK, produce no valid pulse, and go to WAIT_STOP.
REQ-022 SHALL hold data_slave_read until the next accepted byte.
REQ-023 SHALL not support read transfers (R/W=1); these are NACKed per REQ-019.
REQ-024 SHALL ignore SCL/SDA activity in IDLE and WAIT_STOP, except for START and STOP.
REQ-025 SHALL keep busy high in every state except IDLE.
REQ-026 SHALL give START priority if START and an SCL edge are detected in the same cycle (impossible on a legal bus).

Reset
REQ-027 SHALL, while presetn=0, asynchronously force the following:
  - state=IDLE and bit counter=0;
  - sda_oe=0, data_slave_read=8'h00;
  - data_slave_read_valid=0, busy=0, stop_det=0;
  - synchronizer flops=1 (idle bus).
REQ-028 SHALL, after reset deassertion mid-transfer, stay in IDLE until a fresh START is seen.

Structure
REQ-029 SHALL take the following from shared package i2c_pkg:
  - the state enum;
  - I2C_ADDR_W=7 and I2C_DATA_W=8;
  - ACK=1'b0 and NACK=1'b1 constants.
REQ-030 SHALL place the synchronizer and edge detect in sub-module i2c_sync_edge (ports: pclk, presetn, d_i, level_o, rise_o, fall_o), instantiated once each for SCL and SDA.

Verification
REQ-031 SHALL cover a valid write: slave_addr=7'h3A, write 0x74 then data 0xA5, 0x5A, rx_ready=1 -> three ACKs, two valid pulses carrying 0xA5 then 0x5A, busy high throughout, then stop_det pulse.
REQ-032 SHALL cover an address mismatch: address byte 0x42 with slave_addr=7'h3A -> sda_oe never asserted, no valid pulse, busy high until STOP.
REQ-033 SHALL cover a read request: address byte 0x75 -> NACK, state WAIT_STOP, following clocked bytes ignored.
REQ-034 SHALL cover backpressure: rx_ready=0 during the 2nd byte 0x5A -> 1st byte 0xA5 ACKed with a valid pulse, 2nd byte NACKed with no pulse, data_slave_read stays 0xA5.
REQ-035 SHALL cover a repeated START after 4 data bits, followed by 0x74, 0x3C -> partial byte discarded and a single valid pulse with 0x3C.
REQ-036 SHALL cover reset mid-byte: presetn low during the 5th data bit -> all outputs 0 immediately; the next full transfer is received correctly.
